// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels for both ALU requesters, the registered ALU
// operand bus, status and performance counters. The slave modport is the arbiter; the
// master modport is the surrounding control (requesters plus the ALU itself).
interface alu_arbiter_if #(
    parameter int unsigned DATA_LEN  = 64,
    parameter int unsigned FUNCT_LEN = 4,
    parameter int unsigned TAG_LEN   = 4
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [DATA_LEN-1:0]  req0_a;
    logic [DATA_LEN-1:0]  req0_b;
    logic [FUNCT_LEN-1:0] req0_funct;
    logic [TAG_LEN-1:0]   req0_tag;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [DATA_LEN-1:0]  req1_a;
    logic [DATA_LEN-1:0]  req1_b;
    logic [FUNCT_LEN-1:0] req1_funct;
    logic [TAG_LEN-1:0]   req1_tag;

    logic                 resp0_valid;
    logic                 resp0_ready;
    logic [DATA_LEN-1:0]  resp0_result;
    logic [TAG_LEN-1:0]   resp0_tag;

    logic                 resp1_valid;
    logic                 resp1_ready;
    logic [DATA_LEN-1:0]  resp1_result;
    logic [TAG_LEN-1:0]   resp1_tag;

    logic [DATA_LEN-1:0]  alu_a;
    logic [DATA_LEN-1:0]  alu_b;
    logic [FUNCT_LEN-1:0] alu_funct;
    logic [DATA_LEN-1:0]  alu_result;

    logic                 busy;
    logic [31:0]          perf_grant0;
    logic [31:0]          perf_grant1;
    logic [31:0]          perf_conflict;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_funct, req1_tag,
        input  resp0_ready, resp1_ready, alu_result,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_result, resp0_tag,
        output resp1_valid, resp1_result, resp1_tag,
        output alu_a, alu_b, alu_funct,
        output busy, perf_grant0, perf_grant1, perf_conflict
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_funct, req0_tag,
        output req1_valid, req1_a, req1_b, req1_funct, req1_tag,
        output resp0_ready, resp1_ready, alu_result,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_result, resp0_tag,
        input  resp1_valid, resp1_result, resp1_tag,
        input  alu_a, alu_b, alu_funct,
        input  busy, perf_grant0, perf_grant1, perf_conflict
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (port 0) and the
// branch/compare unit (port 1). Round-robin arbitration, one operation in flight, result
// returned to the issuing port with valid/ready backpressure.
// Optional performance counters are built when ALU_ARB_PERF_EN is defined; otherwise the
// perf ports read zero.
module alu_arbiter #(
    parameter int unsigned DATA_LEN  = 64,
    parameter int unsigned FUNCT_LEN = 4,
    parameter int unsigned TAG_LEN   = 4
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q;
    logic                 owner_q;
    logic [DATA_LEN-1:0]  alu_a_q;
    logic [DATA_LEN-1:0]  alu_b_q;
    logic [FUNCT_LEN-1:0] alu_funct_q;
    logic [TAG_LEN-1:0]   tag_q;

    logic                 resp0_valid_q, resp1_valid_q;
    logic [DATA_LEN-1:0]  resp0_result_q, resp1_result_q;
    logic [TAG_LEN-1:0]   resp0_tag_q, resp1_tag_q;

    logic                 grant0, grant1;
    logic                 resp_hs;

    // Round-robin winner: a lone requester wins, on conflict the port not granted last.
    always_comb begin
        grant0  = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        resp_hs = owner_q ? (resp1_valid_q && bus.resp1_ready)
                          : (resp0_valid_q && bus.resp0_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, one EXEC cycle, wait in RESP for the owner to consume.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant0 || grant1) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (resp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: readys only in IDLE and only to the winner; registered buses pass through.
    always_comb begin
        bus.req0_ready   = (state_q == StIdle) && grant0;
        bus.req1_ready   = (state_q == StIdle) && grant1;
        bus.busy         = (state_q != StIdle);
        bus.alu_a        = alu_a_q;
        bus.alu_b        = alu_b_q;
        bus.alu_funct    = alu_funct_q;
        bus.resp0_valid  = resp0_valid_q;
        bus.resp0_result = resp0_result_q;
        bus.resp0_tag    = resp0_tag_q;
        bus.resp1_valid  = resp1_valid_q;
        bus.resp1_result = resp1_result_q;
        bus.resp1_tag    = resp1_tag_q;
    end

    // Operand capture on request handshake; the round-robin pointer follows the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_funct_q  <= '0;
            tag_q        <= '0;
        end else if (state_q == StIdle) begin
            if (grant0) begin
                alu_a_q      <= bus.req0_a;
                alu_b_q      <= bus.req0_b;
                alu_funct_q  <= bus.req0_funct;
                tag_q        <= bus.req0_tag;
                owner_q      <= 1'b0;
                last_grant_q <= 1'b0;
            end else if (grant1) begin
                alu_a_q      <= bus.req1_a;
                alu_b_q      <= bus.req1_b;
                alu_funct_q  <= bus.req1_funct;
                tag_q        <= bus.req1_tag;
                owner_q      <= 1'b1;
                last_grant_q <= 1'b1;
            end
        end
    end

    // Result capture at the end of EXEC; valid drops once the owner consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp0_valid_q  <= 1'b0;
            resp0_result_q <= '0;
            resp0_tag_q    <= '0;
            resp1_valid_q  <= 1'b0;
            resp1_result_q <= '0;
            resp1_tag_q    <= '0;
        end else if (state_q == StExec) begin
            if (owner_q) begin
                resp1_valid_q  <= 1'b1;
                resp1_result_q <= bus.alu_result;
                resp1_tag_q    <= tag_q;
            end else begin
                resp0_valid_q  <= 1'b1;
                resp0_result_q <= bus.alu_result;
                resp0_tag_q    <= tag_q;
            end
        end else if ((state_q == StResp) && resp_hs) begin
            if (owner_q) begin
                resp1_valid_q <= 1'b0;
            end else begin
                resp0_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0_q, perf_grant1_q, perf_conflict_q;

    // Free-running wrap-around counters of grants and dual-request IDLE cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grant0_q   <= '0;
            perf_grant1_q   <= '0;
            perf_conflict_q <= '0;
        end else if (state_q == StIdle) begin
            if (grant0) perf_grant0_q <= perf_grant0_q + 32'd1;
            if (grant1) perf_grant1_q <= perf_grant1_q + 32'd1;
            if (bus.req0_valid && bus.req1_valid) perf_conflict_q <= perf_conflict_q + 32'd1;
        end
    end

    assign bus.perf_grant0   = perf_grant0_q;
    assign bus.perf_grant1   = perf_grant1_q;
    assign bus.perf_conflict = perf_conflict_q;
`else
    assign bus.perf_grant0   = 32'd0;
    assign bus.perf_grant1   = 32'd0;
    assign bus.perf_conflict = 32'd0;
`endif

endmodule
